// File: rtl/jk_excitation_driver_if.sv
// Target request handshake between a requester and jk_excitation_driver.
//   tgt_valid : requester has a target value on tgt_data
//   tgt_ready : driver can accept a target (IDLE only)
//   tgt_data  : requested Q value for the flip-flop bank
// master = requester side, slave = jk_excitation_driver side.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4
) ();
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  modport master (output tgt_valid, output tgt_data, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: controller for a WIDTH-bit bank of JK flip-flops.
// On accepting a target it drives one cycle of J/K excitation derived from
// the bank's current Q, then watches q_fb until it equals the target (done)
// or TIMEOUT check cycles pass without a match (err).
//
// Ports:
//   clk, rst_n     clock (shared with the bank) and async active-low reset
//   tgt            target handshake (jk_excitation_driver_if.slave)
//   q_fb           Q outputs of the controlled bank
//   j_out, k_out   registered J/K inputs of the bank
//   busy           high in DRIVE and CHECK
//   done, err      single-cycle completion / timeout pulses
//
// Build option: define JK_TOGGLE_PREF_EN to drive changing bits as J=K=1
// (toggle) instead of the set/reset encoding (10 / 01). Resulting Q and all
// timing are identical in both builds.

// Per-bit excitation for moving q to t.
module jk_exc_bit (
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);
  logic chg;
  assign chg = q ^ t;
`ifdef JK_TOGGLE_PREF_EN
  assign j = chg;
  assign k = chg;
`else
  assign j = chg & t;
  assign k = chg & ~t;
`endif
endmodule

module jk_excitation_driver #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  jk_excitation_driver_if.slave   tgt,
  input  logic [WIDTH-1:0]        q_fb,
  output logic [WIDTH-1:0]        j_out,
  output logic [WIDTH-1:0]        k_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] tgt_q;
  logic [CW-1:0]    cnt;
  logic             ready;
  logic [WIDTH-1:0] j_nxt, k_nxt;

  // One excitation cell per bank bit, fed by live q_fb and the offered target;
  // only captured on the accept edge.
  jk_exc_bit u_bit [WIDTH-1:0] (
    .q (q_fb),
    .t (tgt.tgt_data),
    .j (j_nxt),
    .k (k_nxt)
  );

  assign tgt.tgt_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tgt_q <= '0;
      cnt   <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      j_out <= '0;
      k_out <= '0;
    end else begin
      // Pulses and excitation default low; excitation lives only in DRIVE.
      done  <= 1'b0;
      err   <= 1'b0;
      j_out <= '0;
      k_out <= '0;
      case (state)
        S_IDLE: begin
          if (tgt.tgt_valid && ready) begin
            tgt_q <= tgt.tgt_data;
            j_out <= j_nxt;
            k_out <= k_nxt;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= S_DRIVE;
          end else begin
            ready <= 1'b1;
          end
        end
        S_DRIVE: begin
          // Bank takes the excitation on this edge; first check cycle is 1.
          cnt   <= CW'(1);
          state <= S_CHECK;
        end
        S_CHECK: begin
          // Match wins over timeout in the final check cycle.
          if (q_fb == tgt_q) begin
            done  <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt == CW'(TIMEOUT)) begin
            err   <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jk_excitation_driver.sv
module tb_jk_excitation_driver;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] q_fb, j_out, k_out;
  logic         busy, done, err;

  int checks = 0;
  int errors = 0;

  jk_excitation_driver_if #(.WIDTH(W)) tif ();

  jk_excitation_driver #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tgt   (tif),
    .q_fb  (q_fb),
    .j_out (j_out),
    .k_out (k_out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Flip-flop bank plant: JK characteristic, preloadable, can be stuck at 0.
  logic [W-1:0] bank_q;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         stuck = 1'b0;
  always @(posedge clk) begin
    if (load)        bank_q <= load_val;
    else if (!stuck) bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
  end
  assign q_fb = stuck ? '0 : bank_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference excitation from the rule: unchanged bits 00, changing bits
  // set/reset (or toggle in the toggle build).
  function automatic logic [2*W-1:0] ref_jk(input logic [W-1:0] q, input logic [W-1:0] t);
    logic [W-1:0] c;
    c = q ^ t;
`ifdef JK_TOGGLE_PREF_EN
    return {c, c};
`else
    return {c & t, c & ~t};
`endif
  endfunction

  // Preload bank, offer target, capture DRIVE-cycle j/k, then find the
  // cycle k (edges after accept) where done or err shows. rel_k>0 releases
  // the stuck fault at that cycle.
  task automatic run(input logic [W-1:0] init, input logic [W-1:0] t,
                     input bit stk, input int rel_k,
                     output int lat, output bit got_done,
                     output logic [W-1:0] dj, output logic [W-1:0] dk);
    @(negedge clk); load = 1'b1; load_val = init; stuck = stk;
    @(negedge clk); load = 1'b0;
    chk("ready_idle", {31'd0, tif.tgt_ready}, 32'd1);
    tif.tgt_valid = 1'b1; tif.tgt_data = t;
    @(negedge clk); tif.tgt_valid = 1'b0;
    dj = j_out; dk = k_out;
    chk("busy_drive", {31'd0, busy}, 32'd1);
    lat = 0; got_done = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done || err) begin
        lat = k; got_done = done;
        if (done && err) chk("done_err_excl", 32'd1, 32'd0);
        break;
      end
      if (k == rel_k) stuck = 1'b0;
    end
    if (lat == 0) chk("completion_timeout", 32'd0, 32'd1);
    stuck = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] init;
    logic [W-1:0] tgt;
    logic [W-1:0] exp_j;
    logic [W-1:0] exp_k;
  } vec_t;

  vec_t vecs[4];
  int lat;
  bit gd;
  logic [W-1:0] dj, dk;
  logic [2*W-1:0] rjk;

  initial begin
    tif.tgt_valid = 1'b0;
    tif.tgt_data  = '0;
`ifdef JK_TOGGLE_PREF_EN
    vecs[0] = '{4'b0000, 4'b1010, 4'b1010, 4'b1010};
    vecs[1] = '{4'b1111, 4'b0110, 4'b1001, 4'b1001};
    vecs[2] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000};
    vecs[3] = '{4'b1100, 4'b0011, 4'b1111, 4'b1111};
`else
    vecs[0] = '{4'b0000, 4'b1010, 4'b1010, 4'b0000};
    vecs[1] = '{4'b1111, 4'b0110, 4'b0000, 4'b1001};
    vecs[2] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000};
    vecs[3] = '{4'b1100, 4'b0011, 4'b0011, 4'b1100};
`endif

    // Reset state
    #12;
    chk("reset_outs", {22'd0, tif.tgt_ready, busy, done, err, j_out, k_out}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    chk("ready_before_clk", {31'd0, tif.tgt_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_release", {31'd0, tif.tgt_ready}, 32'd1);

    // Table vectors
    foreach (vecs[i]) begin
      run(vecs[i].init, vecs[i].tgt, 1'b0, 0, lat, gd, dj, dk);
      chk($sformatf("vec%0d_j", i), {28'd0, dj}, {28'd0, vecs[i].exp_j});
      chk($sformatf("vec%0d_k", i), {28'd0, dk}, {28'd0, vecs[i].exp_k});
      chk($sformatf("vec%0d_lat", i), lat, 32'd2);
      chk($sformatf("vec%0d_done", i), {31'd0, gd}, 32'd1);
      chk($sformatf("vec%0d_q", i), {28'd0, q_fb}, {28'd0, vecs[i].tgt});
    end

    // Stuck bank: err 9 clk after accept, no done
    run(4'b0000, 4'b0011, 1'b1, 0, lat, gd, dj, dk);
    rjk = ref_jk(4'b0000, 4'b0011);
    chk("stuck_jk", {24'd0, dj, dk}, {24'd0, rjk});
    chk("stuck_err_lat", lat, 32'd9);
    chk("stuck_no_done", {31'd0, gd}, 32'd0);

    // Match appearing in the last check cycle still gives done
    run(4'b0011, 4'b0011, 1'b1, 8, lat, gd, dj, dk);
    chk("last_cycle_lat", lat, 32'd9);
    chk("last_cycle_done", {31'd0, gd}, 32'd1);

    // Reset mid-CHECK
    @(negedge clk); load = 1'b1; load_val = 4'b0000; stuck = 1'b1;
    @(negedge clk); load = 1'b0;
    tif.tgt_valid = 1'b1; tif.tgt_data = 4'b0011;
    @(negedge clk); tif.tgt_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", {22'd0, tif.tgt_ready, busy, done, err, j_out, k_out}, 32'd0);
    @(negedge clk); rst_n = 1'b1; stuck = 1'b0;
    begin
      int seen = 0;
      @(negedge clk);
      chk("ready_after_midreset", {31'd0, tif.tgt_ready}, 32'd1);
      for (int i = 0; i < 10; i++) begin
        if (done || err || busy) seen++;
        @(negedge clk);
      end
      chk("no_pulse_after_abort", seen, 32'd0);
    end

    // Valid held with changing data while busy
    @(negedge clk); load = 1'b1; load_val = 4'b0000;
    @(negedge clk); load = 1'b0;
    tif.tgt_valid = 1'b1; tif.tgt_data = 4'b1010;
    lat = 0;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
      if (!busy) chk("busy_hold", 32'd0, 32'd1);
      tif.tgt_data = 4'($urandom);
    end
    chk("hold_lat", lat, 32'd2);
    chk("hold_q", {28'd0, q_fb}, 32'h0000000a);
    chk("hold_ready_on_done", {31'd0, tif.tgt_ready}, 32'd1);
    tif.tgt_data = 4'b0101;
    @(negedge clk); tif.tgt_valid = 1'b0;
    rjk = ref_jk(4'b1010, 4'b0101);
    chk("second_busy", {31'd0, busy}, 32'd1);
    chk("second_jk", {24'd0, j_out, k_out}, {24'd0, rjk});
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done || err) begin lat = k; break; end
    end
    chk("second_lat", lat, 32'd2);
    chk("second_q", {28'd0, q_fb}, 32'h00000005);

    // Randomized against the reference rule
    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] ri, rt;
      ri = 4'($urandom_range(0, 15));
      rt = 4'($urandom_range(0, 15));
      run(ri, rt, 1'b0, 0, lat, gd, dj, dk);
      rjk = ref_jk(ri, rt);
      chk($sformatf("rnd%0d_jk", n), {24'd0, dj, dk}, {24'd0, rjk});
      chk($sformatf("rnd%0d_lat", n), lat, 32'd2);
      chk($sformatf("rnd%0d_q", n), {28'd0, q_fb}, {28'd0, rt});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
